// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, FSM state type and hazard helper for the pipeline controller
//
// Purpose: definitions used by pipe_hazard_ctrl, md_busy_counter and the bench.
//   TUSE_NONE           - Tuse value meaning "operand not read"
//   EXC_*               - CP0 ExcCode values seen in M_ExcCode
//   EXC_VECTOR_DEFAULT  - PC loaded on exception/interrupt
//   hz_state_e          - controller state {RUN, SHADOW}
//   src_hazard()        - RAW check of one D operand against the E and M producers
package pipe_pkg;

  localparam logic [1:0]  TUSE_NONE          = 2'd3;

  localparam logic [4:0]  EXC_INT            = 5'd0;
  localparam logic [4:0]  EXC_ADEL           = 5'd4;
  localparam logic [4:0]  EXC_ADES           = 5'd5;
  localparam logic [4:0]  EXC_RI             = 5'd10;
  localparam logic [4:0]  EXC_OV             = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } hz_state_e;

  // $0 never hazards. TUSE_NONE (3) can never be below a 2-bit Tnew, so the
  // explicit test only documents that an unused operand is skipped.
  function automatic logic src_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    return (addr != 5'd0) && (tuse != TUSE_NONE) &&
           (((addr == e_wa) && (tuse < e_tnew)) ||
            ((addr == m_wa) && (tuse < m_tnew)));
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - busy counter sequencing the multi-cycle mult/div unit
//
// Purpose: loads the operation latency on a start, then counts down to zero.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   start       - gated start of a mult/div in E (load has priority over decrement)
//   is_div      - 1 = div/divu latency, 0 = mult/multu latency
//   busy        - counter nonzero
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  if (MULT_CYCLES > 15 || MULT_CYCLES < 0) begin : g_bad_mult
    $error("md_busy_counter: MULT_CYCLES must fit in 4 bits");
  end
  if (DIV_CYCLES > 15 || DIV_CYCLES < 0) begin : g_bad_div
    $error("md_busy_counter: DIV_CYCLES must fit in 4 bits");
  end

  localparam logic [3:0] MULT_LOAD = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_LOAD  = DIV_CYCLES[3:0];

  logic [3:0] md_cnt;

  // Flushes never touch this counter: an issued MD operation always completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (start) begin
      md_cnt <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign busy = (md_cnt != 4'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush controller for the 5-stage MIPS pipeline
//
// Purpose: each cycle decides F/D stall, D/E bubble and full flush on exception
// or ERET, redirects the PC, and sequences the mult/div busy counter.
// Optional feature macro: PIPE_HAZARD_CTRL_STATS_EN adds StallCnt/ExcCnt.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   D_A1/D_A2, D_TuseRs/Rt     - D-stage operand addresses and need-times
//   D_UsesMD                   - D instruction touches HI/LO or the MD unit
//   E_/M_WriteAddr, E_/M_Tnew  - producer destinations and result-ready times
//   E_MDStart, E_MDIsDiv       - MD start in E and its kind
//   M_ExcCode, IntReq, M_Eret  - exception, interrupt and eret in M
//   EPCIn                      - EPC from CP0 (eret target)
//   StallFD, FlushDE, FlushAll - pipeline register controls
//   PCLoad, PCTarget           - PC redirect
//   EPCWe                      - CP0 captures EPC/Cause
//   MDBusy, MDStartGated       - MD counter busy, start not killed by flush
//   StallCnt, ExcCnt           - (stats build) stall cycles and exceptions taken
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [1:0]  D_TuseRs,
  input  logic [1:0]  D_TuseRt,
  input  logic        D_UsesMD,
  input  logic [4:0]  E_WriteAddr,
  input  logic [4:0]  M_WriteAddr,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        E_MDStart,
  input  logic        E_MDIsDiv,
  input  logic [4:0]  M_ExcCode,
  input  logic        IntReq,
  input  logic        M_Eret,
  input  logic [31:0] EPCIn,
  output logic        StallFD,
  output logic        FlushDE,
  output logic        FlushAll,
  output logic        PCLoad,
  output logic [31:0] PCTarget,
  output logic        EPCWe,
  output logic        MDBusy,
  output logic        MDStartGated
`ifdef PIPE_HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] ExcCnt
`endif
);

  hz_state_e state, state_nxt;
  logic      dstall, mstall, md_busy;

  assign dstall = src_hazard(D_A1, D_TuseRs, E_WriteAddr, E_Tnew, M_WriteAddr, M_Tnew) ||
                  src_hazard(D_A2, D_TuseRt, E_WriteAddr, E_Tnew, M_WriteAddr, M_Tnew);

  // A start in E makes the counter busy next cycle, so D must already wait now.
  assign mstall = D_UsesMD && (md_busy || E_MDStart);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    StallFD   = 1'b0;
    FlushDE   = 1'b0;
    FlushAll  = 1'b0;
    PCLoad    = 1'b0;
    PCTarget  = 32'd0;
    EPCWe     = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if ((M_ExcCode != 5'd0) || IntReq) begin
            FlushAll  = 1'b1;
            PCLoad    = 1'b1;
            PCTarget  = EXC_VECTOR;
            EPCWe     = 1'b1;
            state_nxt = SHADOW;
          end else if (M_Eret) begin
            FlushAll = 1'b1;
            PCLoad   = 1'b1;
            PCTarget = EPCIn;
          end else if (dstall || mstall) begin
            StallFD = 1'b1;
            FlushDE = 1'b1;
          end
        end
        default: begin
          // One cycle after a redirect M holds a bubble; its exception/eret
          // fields are stale and must not retrigger.
          if (dstall || mstall) begin
            StallFD = 1'b1;
            FlushDE = 1'b1;
          end
        end
      endcase
    end
  end

  assign MDStartGated = E_MDStart && !FlushAll && !reset;
  assign MDBusy       = md_busy && !reset;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy (
    .clk   (clk),
    .reset (reset),
    .start (MDStartGated),
    .is_div(E_MDIsDiv),
    .busy  (md_busy)
  );

`ifdef PIPE_HAZARD_CTRL_STATS_EN
  // EPCWe is asserted exactly on the cycles an exception is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= 32'd0;
      ExcCnt   <= 32'd0;
    end else begin
      if (StallFD) StallCnt <= StallCnt + 32'd1;
      if (EPCWe)   ExcCnt   <= ExcCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_A1, D_A2;
  logic [1:0]  D_TuseRs, D_TuseRt;
  logic        D_UsesMD;
  logic [4:0]  E_WriteAddr, M_WriteAddr;
  logic [1:0]  E_Tnew, M_Tnew;
  logic        E_MDStart, E_MDIsDiv;
  logic [4:0]  M_ExcCode;
  logic        IntReq, M_Eret;
  logic [31:0] EPCIn;
  logic        StallFD, FlushDE, FlushAll, PCLoad, EPCWe, MDBusy, MDStartGated;
  logic [31:0] PCTarget;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [31:0] StallCnt, ExcCnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: remaining MD busy cycles and "just redirected" flag.
  bit          m_shadow;
  int          m_md;
  int unsigned m_stalls, m_excs;

  bit          x_stall, x_flde, x_flall, x_pcl, x_epc, x_busy, x_startg;
  logic [31:0] x_tgt;

  // Values observed in the most recent cycle, for directed checks.
  logic        s_stall, s_flall, s_pcl, s_epc, s_busy, s_startg;
  logic [31:0] s_tgt;

  int busy_len, stall_len;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_A1        (D_A1),
    .D_A2        (D_A2),
    .D_TuseRs    (D_TuseRs),
    .D_TuseRt    (D_TuseRt),
    .D_UsesMD    (D_UsesMD),
    .E_WriteAddr (E_WriteAddr),
    .M_WriteAddr (M_WriteAddr),
    .E_Tnew      (E_Tnew),
    .M_Tnew      (M_Tnew),
    .E_MDStart   (E_MDStart),
    .E_MDIsDiv   (E_MDIsDiv),
    .M_ExcCode   (M_ExcCode),
    .IntReq      (IntReq),
    .M_Eret      (M_Eret),
    .EPCIn       (EPCIn),
    .StallFD     (StallFD),
    .FlushDE     (FlushDE),
    .FlushAll    (FlushAll),
    .PCLoad      (PCLoad),
    .PCTarget    (PCTarget),
    .EPCWe       (EPCWe),
    .MDBusy      (MDBusy),
    .MDStartGated(MDStartGated)
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    ,
    .StallCnt    (StallCnt),
    .ExcCnt      (ExcCnt)
`endif
  );

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  function automatic bit hazard(input logic [4:0] a, input logic [1:0] tuse);
    int t;
    t = int'(tuse);
    if (a == 5'd0) return 1'b0;
    return ((a == E_WriteAddr) && (t < int'(E_Tnew))) ||
           ((a == M_WriteAddr) && (t < int'(M_Tnew)));
  endfunction

  task automatic model_reset();
    m_shadow = 1'b0;
    m_md     = 0;
    m_stalls = 0;
    m_excs   = 0;
  endtask

  task automatic predict();
    bit take, eret, stall;
    if (reset) begin
      {x_stall, x_flde, x_flall, x_pcl, x_epc, x_busy, x_startg} = '0;
      x_tgt = 32'd0;
      return;
    end
    take  = !m_shadow && ((M_ExcCode != 5'd0) || IntReq);
    eret  = !m_shadow && !take && M_Eret;
    stall = hazard(D_A1, D_TuseRs) || hazard(D_A2, D_TuseRt) ||
            (D_UsesMD && ((m_md > 0) || E_MDStart));
    x_flall  = take || eret;
    x_pcl    = take || eret;
    x_epc    = take;
    x_tgt    = take ? 32'h0000_4180 : (eret ? EPCIn : 32'd0);
    x_stall  = stall && !x_flall;
    x_flde   = x_stall;
    x_busy   = (m_md > 0);
    x_startg = E_MDStart && !x_flall;
  endtask

  task automatic advance();
    if (reset) begin
      model_reset();
      return;
    end
    if (x_stall) m_stalls++;
    if (x_epc)   m_excs++;
    if (x_startg)      m_md = E_MDIsDiv ? 10 : 5;
    else if (m_md > 0) m_md = m_md - 1;
    m_shadow = x_epc;
  endtask

  task automatic check_all(input string tag);
    predict();
    chk(tag, "StallFD",      StallFD,      x_stall);
    chk(tag, "FlushDE",      FlushDE,      x_flde);
    chk(tag, "FlushAll",     FlushAll,     x_flall);
    chk(tag, "PCLoad",       PCLoad,       x_pcl);
    chk(tag, "PCTarget",     PCTarget,     x_tgt);
    chk(tag, "EPCWe",        EPCWe,        x_epc);
    chk(tag, "MDBusy",       MDBusy,       x_busy);
    chk(tag, "MDStartGated", MDStartGated, x_startg);
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    chk(tag, "StallCnt",     StallCnt,     m_stalls);
    chk(tag, "ExcCnt",       ExcCnt,       m_excs);
`endif
    s_stall = StallFD; s_flall = FlushAll; s_pcl = PCLoad; s_epc = EPCWe;
    s_busy = MDBusy; s_startg = MDStartGated; s_tgt = PCTarget;
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are checked
  // 4 units later, then the model steps on the next rising edge.
  task automatic cycle(input string tag);
    #3;
    if (reset) model_reset();
    check_all(tag);
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic idle();
    D_A1 = 5'd0; D_A2 = 5'd0; D_TuseRs = 2'd3; D_TuseRt = 2'd3; D_UsesMD = 1'b0;
    E_WriteAddr = 5'd0; M_WriteAddr = 5'd0; E_Tnew = 2'd0; M_Tnew = 2'd0;
    E_MDStart = 1'b0; E_MDIsDiv = 1'b0; M_ExcCode = 5'd0; IntReq = 1'b0;
    M_Eret = 1'b0; EPCIn = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    @(posedge clk); #1;
    cycle("reset0");
    chk("reset0", "all_out", {StallFD, FlushDE, FlushAll, PCLoad, EPCWe, MDBusy, MDStartGated}, 32'd0);
    cycle("reset1");
    reset = 1'b0;
    cycle("idle");

    // RAW load-use: lw in E writing $8, D reads $8 next cycle
    E_WriteAddr = 5'd8; E_Tnew = 2'd2; D_A1 = 5'd8; D_TuseRs = 2'd1;
    cycle("raw_lw");
    chk("raw_lw", "stall", s_stall, 1'b1);
    E_WriteAddr = 5'd0; E_Tnew = 2'd0; M_WriteAddr = 5'd8; M_Tnew = 2'd1;
    cycle("raw_lw_m");
    chk("raw_lw_m", "stall", s_stall, 1'b0);

    // $0 never hazards
    idle();
    D_A1 = 5'd0; D_TuseRs = 2'd0; E_WriteAddr = 5'd0; E_Tnew = 2'd2;
    cycle("zero_reg");
    chk("zero_reg", "stall", s_stall, 1'b0);
    // rt operand
    idle();
    D_A2 = 5'd5; D_TuseRt = 2'd0; M_WriteAddr = 5'd5; M_Tnew = 2'd1;
    cycle("rt_m");
    chk("rt_m", "stall", s_stall, 1'b1);

    // div with mflo waiting in D
    idle();
    E_MDStart = 1'b1; E_MDIsDiv = 1'b1; D_UsesMD = 1'b1;
    cycle("div_start");
    chk("div_start", "stall", s_stall, 1'b1);
    E_MDStart = 1'b0;
    busy_len = 0; stall_len = 0;
    for (int i = 0; i < 13; i++) begin
      cycle("div_run");
      busy_len += int'(s_busy);
      stall_len += int'(s_stall);
    end
    chk("div", "busy_len", busy_len, 10);
    chk("div", "stall_len", stall_len, 10);

    // mult variant
    idle();
    E_MDStart = 1'b1; D_UsesMD = 1'b1;
    cycle("mult_start");
    E_MDStart = 1'b0;
    busy_len = 0;
    for (int i = 0; i < 8; i++) begin
      cycle("mult_run");
      busy_len += int'(s_busy);
    end
    chk("mult", "busy_len", busy_len, 5);

    // exception coincident with an MD start
    idle();
    M_ExcCode = EXC_OV; E_MDStart = 1'b1; E_MDIsDiv = 1'b1;
    cycle("exc_ov");
    chk("exc_ov", "flush", s_flall, 1'b1);
    chk("exc_ov", "epcwe", s_epc, 1'b1);
    chk("exc_ov", "target", s_tgt, 32'h0000_4180);
    chk("exc_ov", "startg", s_startg, 1'b0);
    idle();
    IntReq = 1'b1;
    cycle("shadow_int");
    chk("shadow_int", "flush", s_flall, 1'b0);
    chk("shadow_int", "busy", s_busy, 1'b0);
    cycle("int_run");
    chk("int_run", "flush", s_flall, 1'b1);
    idle();
    cycle("post_int");

    // eret wins over a concurrent data stall
    E_WriteAddr = 5'd8; E_Tnew = 2'd2; D_A1 = 5'd8; D_TuseRs = 2'd0;
    M_Eret = 1'b1; EPCIn = 32'h0000_3010;
    cycle("eret");
    chk("eret", "target", s_tgt, 32'h0000_3010);
    chk("eret", "stall", s_stall, 1'b0);
    chk("eret", "pcload", s_pcl, 1'b1);
    idle();
    cycle("post_eret");

    // reset while md_cnt = 7 and in SHADOW
    E_MDStart = 1'b1; E_MDIsDiv = 1'b1;
    cycle("mr_start");
    E_MDStart = 1'b0;
    cycle("mr_9");
    cycle("mr_8");
    M_ExcCode = EXC_RI;
    cycle("mr_exc");
    D_UsesMD = 1'b1; IntReq = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    chk("mid_reset", "busy", s_busy, 1'b0);
    @(posedge clk); #1;
    cycle("mr_hold");
    reset = 1'b0;
    idle();
    IntReq = 1'b1;
    cycle("mr_after");
    chk("mr_after", "flush", s_flall, 1'b1);
    chk("mr_after", "busy", s_busy, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      D_A1        = 5'($urandom_range(0, 3));
      D_A2        = 5'($urandom_range(0, 3));
      D_TuseRs    = 2'($urandom_range(0, 3));
      D_TuseRt    = 2'($urandom_range(0, 3));
      D_UsesMD    = ($urandom_range(0, 3) == 0);
      E_WriteAddr = 5'($urandom_range(0, 3));
      M_WriteAddr = 5'($urandom_range(0, 3));
      E_Tnew      = 2'($urandom_range(0, 3));
      M_Tnew      = 2'($urandom_range(0, 3));
      E_MDStart   = ($urandom_range(0, 9) == 0);
      E_MDIsDiv   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 14))
        0:       M_ExcCode = EXC_RI;
        1:       M_ExcCode = EXC_OV;
        2:       M_ExcCode = EXC_ADEL;
        default: M_ExcCode = EXC_INT;
      endcase
      IntReq      = ($urandom_range(0, 19) == 0);
      M_Eret      = ($urandom_range(0, 14) == 0);
      EPCIn       = $urandom;
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core with exceptions.
- Decides each cycle whether the F/D registers stall, whether D/E takes a bubble, and whether all pipeline registers flush on an exception or ERET.
- Sequences the multi-cycle mult/div unit through a busy counter.
- Consumes the Tnew/write-address fields carried by the D/E and E/M pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception or interrupt.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- D_A1, D_A2  in  5 each  rs/rt read addresses of the instruction in D.
- D_TuseRs, D_TuseRt  in  2 each  cycles until D needs rs/rt; 3 = not used.
- D_UsesMD  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_WriteAddr, M_WriteAddr  in  5 each  destination register in E/M.
- E_Tnew, M_Tnew  in  2 each  cycles until the result is produced.
- E_MDStart  in  1  E instruction starts the MD unit this cycle.
- E_MDIsDiv  in  1  1 = div/divu, 0 = mult/multu.
- M_ExcCode  in  5  nonzero = exception in M.
- IntReq  in  1  interrupt request from CP0.
- M_Eret  in  1  eret in M.
- EPCIn  in  32  current EPC from CP0.
- StallFD  out  1  hold PC and F/D.
- FlushDE  out  1  load bubble into D/E.
- FlushAll  out  1  clear F/D, D/E, E/M.
- PCLoad  out  1  redirect PC to PCTarget.
- PCTarget  out  32  redirect address.
- EPCWe  out  1  CP0 latches EPC/Cause this cycle.
- MDBusy  out  1  MD counter nonzero.
- MDStartGated  out  1  E_MDStart && !FlushAll.

Behaviour:
- State registers: FSM state {RUN, SHADOW} and a 4-bit md_cnt. Reset: RUN, md_cnt = 0.
- Outputs are combinational from inputs and state. During reset every output is 0 and PCTarget = 0.
- Data stall (dstall): set if either operand hazards.
  - rs hazards when D_A1 != 0 and either:
    - D_A1 == E_WriteAddr and D_TuseRs < E_Tnew, or
    - D_A1 == M_WriteAddr and D_TuseRs < M_Tnew.
  - rt uses the same rule with D_A2 and D_TuseRt.
- MD stall (mstall): D_UsesMD && (md_cnt != 0 || E_MDStart).
- exc_take: state == RUN && (M_ExcCode != 0 || IntReq).
- RUN, priority from highest:
  1. exc_take: FlushAll = 1, PCLoad = 1, PCTarget = EXC_VECTOR, EPCWe = 1, StallFD = 0, FlushDE = 0. Next state SHADOW.
  2. M_Eret: FlushAll = 1, PCLoad = 1, PCTarget = EPCIn. Stay in RUN.
  3. dstall || mstall: StallFD = 1, FlushDE = 1.
  4. Otherwise all control outputs 0.
- SHADOW lasts exactly one cycle, then RUN.
  - IntReq, M_ExcCode and M_Eret are ignored; the pipeline holds bubbles.
  - dstall and mstall are still evaluated normally.
- MD counter: evaluated in both states.
  - When MDStartGated: load MULT_CYCLES or DIV_CYCLES per E_MDIsDiv. Load overrides decrement.
  - Else if md_cnt != 0: decrement.
  - MDBusy = (md_cnt != 0). The counter is never cleared by a flush; an in-flight MD operation completes.
- A start flushed by an exception in the same cycle is suppressed (MDStartGated = 0).
- Reset asserted mid-operation immediately forces RUN, md_cnt = 0 and all outputs 0.
- Elaboration check: MULT_CYCLES and DIV_CYCLES must each be ≤ 15 (4-bit counter).

Optional Feature:
- Macro PIPE_HAZARD_CTRL_STATS_EN.
- Defined: adds output ports StallCnt (32) and ExcCnt (32).
  - StallCnt increments each cycle StallFD = 1.
  - ExcCnt increments on each exc_take.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package pipe_pkg holds:
  - TUSE_NONE = 2'd3.
  - ExcCode constants (e.g. EXC_INT = 5'd0, EXC_RI = 5'd10, EXC_OV = 5'd12).
  - EXC_VECTOR default.
  - FSM state typedef {RUN, SHADOW}.
- One natural sub-module: md_busy_counter (load/decrement/busy).

Test Plan:
- RAW load-use: E holds lw, E_WriteAddr = 8, E_Tnew = 2; D has D_A1 = 8, D_TuseRs = 1 -> StallFD = FlushDE = 1. Next cycle M_Tnew = 1, E empty -> no stall.
- $0 hazard: D_A1 = 0, E_WriteAddr = 0, E_Tnew = 2 -> no stall.
- MD sequencing:
  - E_MDStart = 1, E_MDIsDiv = 1 -> MDBusy high for 10 cycles.
  - mflo in D stalls from the start cycle through the last busy cycle, then proceeds.
  - mult variant -> 5 cycles.
- Exception:
  - M_ExcCode = 12 -> same cycle FlushAll = PCLoad = EPCWe = 1, PCTarget = 0x4180.
  - IntReq = 1 in the following cycle -> ignored (SHADOW).
  - Exception coincident with E_MDStart -> MDStartGated = 0, md_cnt unchanged.
- ERET with a concurrent dstall: M_Eret = 1, EPCIn = 0x3010 -> FlushAll = 1, PCLoad = 1, PCTarget = 0x3010, StallFD = 0.
- Mid-operation reset: assert reset while md_cnt = 7 and in SHADOW -> outputs 0 immediately, RUN and md_cnt = 0 after release.
- With PIPE_HAZARD_CTRL_STATS_EN: StallCnt and ExcCnt match the counts in the scenarios above.
